cajero_automatico: RTL and testbench
====================================

// Module: cajero_automatico
// PURPOSE
//  ATM transaction controller FSM. Accepts a card and a 4-digit PIN entered one digit at a time.
//  Checks the PIN against the card PIN. Runs one deposit or withdrawal against an internal balance.
//  Flags fees, insufficient funds, wrong PIN, a warning after two failures and a lockout after three.
//  Top-level leaf, driven by a stimulus block in the bench.
// PARAMETERS
//  BALANCE_INICIAL  64'd50000  balance loaded at reset
//  COMISION_FIJA    32'd100    fee added to withdrawals made with a foreign card
// PORTS
//  clk                   in   1   single clock, rising edge
//  reset                 in   1   asynchronous, active-low reset
//  TARJETA_RECIBIDA      in   1   level: card inserted
//  TIPO_DE_TARJETA       in   1   0 = own bank, 1 = other bank (fee applies)
//  PIN                   in   16  correct PIN from the card, 4 BCD nibbles, [15:12] is the first digit
//  DIGITO                in   4   keypad digit
//  DIGITO_STB            in   1   1-cycle strobe: DIGITO is valid
//  TIPO_TRANS            in   1   0 = deposit, 1 = withdrawal; sampled with MONTO_STB
//  MONTO                 in   32  amount; sampled with MONTO_STB
//  MONTO_STB             in   1   1-cycle strobe: amount and type valid
//  BALANCE_ACTUALIZADO   out  1   1-cycle pulse: balance was changed
//  ENTREGAR_DINERO       out  1   1-cycle pulse: dispense cash
//  FONDOS_INSUFICIENTES  out  1   1-cycle pulse: withdrawal rejected
//  PIN_INCORRECTO        out  1   1-cycle pulse: 4-digit PIN did not match
//  ADVERTENCIA           out  1   level: two consecutive failures; held until the session ends
//  BLOQUEO               out  1   level: locked after the third failure; held until reset
//  COMISION              out  1   1-cycle pulse: fee charged (foreign-card withdrawal accepted)
// BEHAVIOUR
//  - All outputs are registered. Reset (reset=0, async) clears every output to 0.
//    Reset also sets balance=BALANCE_INICIAL, failure count=0, digit count=0 and state=IDLE.
//  - Reset mid-operation aborts the session with no balance change.
//  - States: IDLE, PIN_ENTRY, CHECK, WAIT_MONTO, TRANS, LOCKED, DONE.
//  - IDLE: when TARJETA_RECIBIDA=1, go to PIN_ENTRY and clear the digit shift register.
//    The card type is latched on the same edge.
//  - PIN_ENTRY: each DIGITO_STB shifts DIGITO into a 16-bit register from the low end, so the
//    first digit lands in [15:12]. Strobes while not in PIN_ENTRY are ignored.
//    After the 4th strobe, go to CHECK.
//  - CHECK (1 cycle):
//    . Match: clear the failure count, clear ADVERTENCIA, go to WAIT_MONTO.
//    . Mismatch: fail+1, pulse PIN_INCORRECTO.
//      fail=2: set ADVERTENCIA and return to PIN_ENTRY.
//      fail=3: set BLOQUEO and go to LOCKED.
//      Otherwise return to PIN_ENTRY.
//  - LOCKED: absorbing. Every input is ignored and BLOQUEO=1 until reset.
//  - WAIT_MONTO: on MONTO_STB, latch TIPO_TRANS and MONTO, then go to TRANS.
//  - TRANS (1 cycle); cost = MONTO + (foreign ? COMISION_FIJA : 0), computed at 64-bit width:
//    . Deposit: balance += MONTO (no fee), pulse BALANCE_ACTUALIZADO.
//    . Withdrawal with cost <= balance: balance -= cost, pulse BALANCE_ACTUALIZADO and
//      ENTREGAR_DINERO, plus COMISION if the card is foreign.
//    . Withdrawal with cost > balance: pulse FONDOS_INSUFICIENTES only; balance unchanged.
//    . Boundary: cost == balance is accepted and leaves balance=0.
//    . After any branch, go to DONE.
//  - DONE: clear ADVERTENCIA; go to IDLE when TARJETA_RECIBIDA=0.
//  - Card removal (TARJETA_RECIBIDA=0) in PIN_ENTRY or WAIT_MONTO returns to IDLE and clears
//    ADVERTENCIA. The failure count is kept.
//  - Deposit overflow wraps modulo 2^64; no flag.
//  - At most one pulse event group per cycle. Pulses appear the cycle after the decision state.
// STRUCTURE
//  - Shared package: state encoding (localparams), TRANS_DEPOSITO/TRANS_RETIRO, TARJETA_PROPIA/AJENA.
//  - Single module. One always block for state and data registers; one combinational
//    next-state/decision block. No sub-modules.
// TESTING
//  - Own card, PIN=16'h1234, digits 1,2,3,4, deposit 500:
//    BALANCE_ACTUALIZADO pulse, balance 50500, no COMISION.
//  - Own card, PIN OK, withdraw 20000: BALANCE_ACTUALIZADO + ENTREGAR_DINERO pulses, balance 30000.
//  - Foreign card, PIN OK, withdraw 1000: ENTREGAR_DINERO + COMISION pulses, balance 48900.
//  - Withdraw 60000 (balance 50000): FONDOS_INSUFICIENTES pulse, no ENTREGAR_DINERO, balance 50000.
//  - Wrong PIN 1,1,1,1 three times:
//    PIN_INCORRECTO x3, ADVERTENCIA=1 after the 2nd, BLOQUEO=1 after the 3rd.
//    Further strobes have no effect. reset=0 clears BLOQUEO.
//  - Two wrong PINs then the correct one: ADVERTENCIA drops in CHECK and the withdrawal proceeds.
//  - Assert reset=0 during PIN_ENTRY: state IDLE, all outputs 0, balance 50000.

Source files
------------

// File: rtl/cajero_automatico_pkg.sv
// Shared encodings for the ATM transaction controller.
// States, transaction kinds and card kinds.
package cajero_automatico_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      PIN_ENTRY  = 3'd1,
      CHECK      = 3'd2,
      WAIT_MONTO = 3'd3,
      TRANS      = 3'd4,
      LOCKED     = 3'd5,
      DONE       = 3'd6
   } estado_t;

   localparam logic TRANS_DEPOSITO = 1'b0;
   localparam logic TRANS_RETIRO   = 1'b1;

   localparam logic TARJETA_PROPIA = 1'b0;
   localparam logic TARJETA_AJENA  = 1'b1;

   localparam int unsigned MAX_FALLOS = 3;

endpackage

// File: rtl/cajero_automatico.sv
// ATM transaction controller: PIN entry, PIN check with lockout,
// and a single deposit or withdrawal against an internal balance.
module cajero_automatico
   import cajero_automatico_pkg::*;
#(
   parameter logic [63:0] BALANCE_INICIAL = 64'd50000,
   parameter logic [31:0] COMISION_FIJA   = 32'd100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        TARJETA_RECIBIDA,
   input  logic        TIPO_DE_TARJETA,
   input  logic [15:0] PIN,
   input  logic [3:0]  DIGITO,
   input  logic        DIGITO_STB,
   input  logic        TIPO_TRANS,
   input  logic [31:0] MONTO,
   input  logic        MONTO_STB,
   output logic        BALANCE_ACTUALIZADO,
   output logic        ENTREGAR_DINERO,
   output logic        FONDOS_INSUFICIENTES,
   output logic        PIN_INCORRECTO,
   output logic        ADVERTENCIA,
   output logic        BLOQUEO,
   output logic        COMISION
);

   estado_t     state, nxt_state;
   logic [63:0] balance, nxt_balance;
   logic [1:0]  fail_cnt, nxt_fail_cnt;
   logic [1:0]  dig_cnt, nxt_dig_cnt;
   logic [15:0] pin_sr, nxt_pin_sr;
   logic        ajena, nxt_ajena;
   logic        tipo, nxt_tipo;
   logic [31:0] monto, nxt_monto;

   logic        nxt_bal_act, nxt_entregar, nxt_fondos;
   logic        nxt_pin_inc, nxt_adv, nxt_bloqueo, nxt_comision;

   logic [63:0] costo;
   logic [1:0]  fail_inc;

   // Cost is widened before adding the fee so it never wraps.
   assign costo = {32'd0, monto} +
                  ((ajena == TARJETA_AJENA) ? {32'd0, COMISION_FIJA} : 64'd0);
   assign fail_inc = fail_cnt + 2'd1;

   always_comb begin
      nxt_state    = state;
      nxt_balance  = balance;
      nxt_fail_cnt = fail_cnt;
      nxt_dig_cnt  = dig_cnt;
      nxt_pin_sr   = pin_sr;
      nxt_ajena    = ajena;
      nxt_tipo     = tipo;
      nxt_monto    = monto;
      nxt_bal_act  = 1'b0;
      nxt_entregar = 1'b0;
      nxt_fondos   = 1'b0;
      nxt_pin_inc  = 1'b0;
      nxt_comision = 1'b0;
      nxt_adv      = ADVERTENCIA;
      nxt_bloqueo  = BLOQUEO;

      unique case (state)
         IDLE: begin
            if (TARJETA_RECIBIDA) begin
               nxt_state   = PIN_ENTRY;
               nxt_pin_sr  = 16'd0;
               nxt_dig_cnt = 2'd0;
               nxt_ajena   = TIPO_DE_TARJETA;
            end
         end
         PIN_ENTRY: begin
            if (!TARJETA_RECIBIDA) begin
               nxt_state = IDLE;
               nxt_adv   = 1'b0;
            end else if (DIGITO_STB) begin
               nxt_pin_sr  = {pin_sr[11:0], DIGITO};
               nxt_dig_cnt = dig_cnt + 2'd1;
               if (dig_cnt == 2'd3)
                  nxt_state = CHECK;
            end
         end
         CHECK: begin
            nxt_dig_cnt = 2'd0;
            nxt_pin_sr  = 16'd0;
            if (pin_sr == PIN) begin
               nxt_fail_cnt = 2'd0;
               nxt_adv      = 1'b0;
               nxt_state    = WAIT_MONTO;
            end else begin
               nxt_fail_cnt = fail_inc;
               nxt_pin_inc  = 1'b1;
               nxt_state    = PIN_ENTRY;
               if (fail_inc == 2'd2)
                  nxt_adv = 1'b1;
               if (32'(fail_inc) == MAX_FALLOS) begin
                  nxt_bloqueo = 1'b1;
                  nxt_state   = LOCKED;
               end
            end
         end
         WAIT_MONTO: begin
            if (!TARJETA_RECIBIDA) begin
               nxt_state = IDLE;
               nxt_adv   = 1'b0;
            end else if (MONTO_STB) begin
               nxt_tipo  = TIPO_TRANS;
               nxt_monto = MONTO;
               nxt_state = TRANS;
            end
         end
         TRANS: begin
            nxt_state = DONE;
            if (tipo == TRANS_DEPOSITO) begin
               nxt_balance = balance + {32'd0, monto};
               nxt_bal_act = 1'b1;
            end else if (costo <= balance) begin
               nxt_balance  = balance - costo;
               nxt_bal_act  = 1'b1;
               nxt_entregar = 1'b1;
               nxt_comision = (ajena == TARJETA_AJENA);
            end else begin
               nxt_fondos = 1'b1;
            end
         end
         LOCKED: begin
            nxt_bloqueo = 1'b1;
         end
         DONE: begin
            nxt_adv = 1'b0;
            if (!TARJETA_RECIBIDA)
               nxt_state = IDLE;
         end
         default: begin
            nxt_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                <= IDLE;
         balance              <= BALANCE_INICIAL;
         fail_cnt             <= 2'd0;
         dig_cnt              <= 2'd0;
         pin_sr               <= 16'd0;
         ajena                <= TARJETA_PROPIA;
         tipo                 <= TRANS_DEPOSITO;
         monto                <= 32'd0;
         BALANCE_ACTUALIZADO  <= 1'b0;
         ENTREGAR_DINERO      <= 1'b0;
         FONDOS_INSUFICIENTES <= 1'b0;
         PIN_INCORRECTO       <= 1'b0;
         ADVERTENCIA          <= 1'b0;
         BLOQUEO              <= 1'b0;
         COMISION             <= 1'b0;
      end else begin
         state                <= nxt_state;
         balance              <= nxt_balance;
         fail_cnt             <= nxt_fail_cnt;
         dig_cnt              <= nxt_dig_cnt;
         pin_sr               <= nxt_pin_sr;
         ajena                <= nxt_ajena;
         tipo                 <= nxt_tipo;
         monto                <= nxt_monto;
         BALANCE_ACTUALIZADO  <= nxt_bal_act;
         ENTREGAR_DINERO      <= nxt_entregar;
         FONDOS_INSUFICIENTES <= nxt_fondos;
         PIN_INCORRECTO       <= nxt_pin_inc;
         ADVERTENCIA          <= nxt_adv;
         BLOQUEO              <= nxt_bloqueo;
         COMISION             <= nxt_comision;
      end
   end

endmodule

// File: tb/tb_cajero_automatico.sv
// Directed bench for the ATM controller: sessions, fees,
// insufficient funds, lockout and asynchronous reset.
module tb_cajero_automatico;
   import cajero_automatico_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        TARJETA_RECIBIDA;
   logic        TIPO_DE_TARJETA;
   logic [15:0] PIN;
   logic [3:0]  DIGITO;
   logic        DIGITO_STB;
   logic        TIPO_TRANS;
   logic [31:0] MONTO;
   logic        MONTO_STB;
   logic        BALANCE_ACTUALIZADO;
   logic        ENTREGAR_DINERO;
   logic        FONDOS_INSUFICIENTES;
   logic        PIN_INCORRECTO;
   logic        ADVERTENCIA;
   logic        BLOQUEO;
   logic        COMISION;

   int passed = 0;
   int total  = 0;
   int n_bal, n_ent, n_fon, n_pin, n_com;

   cajero_automatico dut (
      .clk                  (clk),
      .reset                (reset),
      .TARJETA_RECIBIDA     (TARJETA_RECIBIDA),
      .TIPO_DE_TARJETA      (TIPO_DE_TARJETA),
      .PIN                  (PIN),
      .DIGITO               (DIGITO),
      .DIGITO_STB           (DIGITO_STB),
      .TIPO_TRANS           (TIPO_TRANS),
      .MONTO                (MONTO),
      .MONTO_STB            (MONTO_STB),
      .BALANCE_ACTUALIZADO  (BALANCE_ACTUALIZADO),
      .ENTREGAR_DINERO      (ENTREGAR_DINERO),
      .FONDOS_INSUFICIENTES (FONDOS_INSUFICIENTES),
      .PIN_INCORRECTO       (PIN_INCORRECTO),
      .ADVERTENCIA          (ADVERTENCIA),
      .BLOQUEO              (BLOQUEO),
      .COMISION             (COMISION)
   );

   always #5 clk = ~clk;

   task automatic clr();
      n_bal = 0; n_ent = 0; n_fon = 0; n_pin = 0; n_com = 0;
   endtask

   // Advance one cycle and tally any output pulses seen.
   task automatic step();
      @(posedge clk);
      #1;
      n_bal += int'(BALANCE_ACTUALIZADO);
      n_ent += int'(ENTREGAR_DINERO);
      n_fon += int'(FONDOS_INSUFICIENTES);
      n_pin += int'(PIN_INCORRECTO);
      n_com += int'(COMISION);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      TARJETA_RECIBIDA = 1'b0;
      TIPO_DE_TARJETA = 1'b0;
      PIN = 16'h1234;
      DIGITO = 4'd0;
      DIGITO_STB = 1'b0;
      TIPO_TRANS = 1'b0;
      MONTO = 32'd0;
      MONTO_STB = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      clr();
   endtask

   task automatic insert(input logic ajena);
      TIPO_DE_TARJETA = ajena;
      TARJETA_RECIBIDA = 1'b1;
      step();
   endtask

   task automatic remove_card();
      TARJETA_RECIBIDA = 1'b0;
      step();
   endtask

   task automatic enter_pin(input logic [15:0] d);
      for (int i = 0; i < 4; i++) begin
         DIGITO = d[15 - 4*i -: 4];
         DIGITO_STB = 1'b1;
         step();
         DIGITO_STB = 1'b0;
      end
      step();
   endtask

   task automatic transact(input logic t, input logic [31:0] m);
      TIPO_TRANS = t;
      MONTO = m;
      MONTO_STB = 1'b1;
      step();
      MONTO_STB = 1'b0;
      step();
   endtask

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else
         passed++;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES,
           PIN_INCORRECTO, ADVERTENCIA, BLOQUEO, COMISION} !== 7'd0)
         $display("FAIL reset_outputs: got nonzero outputs expected 0");
      else
         passed++;
      chk("reset_balance", dut.balance, 64'd50000);
      chk("reset_state", 64'(dut.state), 64'(IDLE));
   endtask

   task automatic test_deposit();
      do_reset();
      insert(TARJETA_PROPIA);
      enter_pin(16'h1234);
      chk("dep_pin_ok", 64'(n_pin), 64'd0);
      chk("dep_wait_state", 64'(dut.state), 64'(WAIT_MONTO));
      transact(TRANS_DEPOSITO, 32'd500);
      chk("dep_bal_pulse", 64'(n_bal), 64'd1);
      chk("dep_no_com", 64'(n_com), 64'd0);
      chk("dep_no_entregar", 64'(n_ent), 64'd0);
      chk("dep_balance", dut.balance, 64'd50500);
      remove_card();
      chk("dep_idle", 64'(dut.state), 64'(IDLE));
   endtask

   task automatic test_withdraw_own();
      do_reset();
      insert(TARJETA_PROPIA);
      enter_pin(16'h1234);
      transact(TRANS_RETIRO, 32'd20000);
      chk("wown_bal_pulse", 64'(n_bal), 64'd1);
      chk("wown_entregar", 64'(n_ent), 64'd1);
      chk("wown_no_com", 64'(n_com), 64'd0);
      chk("wown_balance", dut.balance, 64'd30000);
      remove_card();
   endtask

   task automatic test_withdraw_foreign();
      do_reset();
      insert(TARJETA_AJENA);
      enter_pin(16'h1234);
      transact(TRANS_RETIRO, 32'd1000);
      chk("wfor_entregar", 64'(n_ent), 64'd1);
      chk("wfor_com", 64'(n_com), 64'd1);
      chk("wfor_balance", dut.balance, 64'd48900);
      remove_card();
   endtask

   task automatic test_insufficient();
      do_reset();
      insert(TARJETA_PROPIA);
      enter_pin(16'h1234);
      transact(TRANS_RETIRO, 32'd60000);
      chk("insuf_pulse", 64'(n_fon), 64'd1);
      chk("insuf_no_entregar", 64'(n_ent), 64'd0);
      chk("insuf_no_bal", 64'(n_bal), 64'd0);
      chk("insuf_balance", dut.balance, 64'd50000);
      remove_card();
   endtask

   task automatic test_boundary();
      do_reset();
      insert(TARJETA_AJENA);
      enter_pin(16'h1234);
      transact(TRANS_RETIRO, 32'd49900);
      chk("bound_entregar", 64'(n_ent), 64'd1);
      chk("bound_com", 64'(n_com), 64'd1);
      chk("bound_no_fon", 64'(n_fon), 64'd0);
      chk("bound_balance", dut.balance, 64'd0);
      remove_card();
      clr();
      insert(TARJETA_PROPIA);
      enter_pin(16'h1234);
      transact(TRANS_RETIRO, 32'd1);
      chk("bound_empty_fon", 64'(n_fon), 64'd1);
      remove_card();
   endtask

   task automatic test_lockout();
      do_reset();
      insert(TARJETA_PROPIA);
      enter_pin(16'h1111);
      chk("lock_pin1", 64'(n_pin), 64'd1);
      chk("lock_adv1", 64'(ADVERTENCIA), 64'd0);
      enter_pin(16'h1111);
      chk("lock_pin2", 64'(n_pin), 64'd2);
      chk("lock_adv2", 64'(ADVERTENCIA), 64'd1);
      chk("lock_bloq2", 64'(BLOQUEO), 64'd0);
      enter_pin(16'h1111);
      chk("lock_pin3", 64'(n_pin), 64'd3);
      chk("lock_bloq3", 64'(BLOQUEO), 64'd1);
      chk("lock_state", 64'(dut.state), 64'(LOCKED));
      enter_pin(16'h1234);
      transact(TRANS_DEPOSITO, 32'd700);
      remove_card();
      chk("lock_absorb_pin", 64'(n_pin), 64'd3);
      chk("lock_absorb_bal", 64'(n_bal), 64'd0);
      chk("lock_absorb_bloq", 64'(BLOQUEO), 64'd1);
      chk("lock_absorb_state", 64'(dut.state), 64'(LOCKED));
      do_reset();
      chk("lock_reset_bloq", 64'(BLOQUEO), 64'd0);
   endtask

   task automatic test_recover();
      do_reset();
      insert(TARJETA_PROPIA);
      enter_pin(16'h9999);
      enter_pin(16'h4321);
      chk("rec_adv_set", 64'(ADVERTENCIA), 64'd1);
      enter_pin(16'h1234);
      chk("rec_adv_clear", 64'(ADVERTENCIA), 64'd0);
      chk("rec_state", 64'(dut.state), 64'(WAIT_MONTO));
      transact(TRANS_RETIRO, 32'd1000);
      chk("rec_entregar", 64'(n_ent), 64'd1);
      chk("rec_balance", dut.balance, 64'd49000);
      remove_card();
   endtask

   task automatic test_fail_kept();
      do_reset();
      insert(TARJETA_PROPIA);
      enter_pin(16'h1111);
      remove_card();
      chk("kept_idle", 64'(dut.state), 64'(IDLE));
      insert(TARJETA_PROPIA);
      enter_pin(16'h1111);
      chk("kept_adv", 64'(ADVERTENCIA), 64'd1);
      remove_card();
      chk("kept_adv_drop", 64'(ADVERTENCIA), 64'd0);
   endtask

   task automatic test_reset_mid();
      do_reset();
      insert(TARJETA_PROPIA);
      enter_pin(16'h5555);
      enter_pin(16'h5555);
      DIGITO = 4'd1;
      DIGITO_STB = 1'b1;
      step();
      DIGITO_STB = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("mid_state", 64'(dut.state), 64'(IDLE));
      chk("mid_adv", 64'(ADVERTENCIA), 64'd0);
      chk("mid_balance", dut.balance, 64'd50000);
      do_reset();
   endtask

   task automatic test_back_to_back();
      do_reset();
      insert(TARJETA_PROPIA);
      enter_pin(16'h1234);
      transact(TRANS_DEPOSITO, 32'd500);
      remove_card();
      insert(TARJETA_AJENA);
      enter_pin(16'h1234);
      transact(TRANS_RETIRO, 32'd500);
      remove_card();
      chk("b2b_bal_pulses", 64'(n_bal), 64'd2);
      chk("b2b_com", 64'(n_com), 64'd1);
      chk("b2b_balance", dut.balance, 64'd49900);
   endtask

   initial begin
      test_reset();
      test_deposit();
      test_withdraw_own();
      test_withdraw_foreign();
      test_insufficient();
      test_boundary();
      test_lockout();
      test_recover();
      test_fail_kept();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
